// File: rtl/nand_updown_counter_pkg.sv
// Shared constants and types for the NAND-cell up/down counter.
//   DEFAULT_WIDTH      : default counter width
//   MODE_WRAP/MODE_SAT : boundary behaviour selectors for SATURATE
//   op_e               : decoded per-edge operation (priority already resolved)
package nand_updown_counter_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;
  localparam int unsigned MIN_WIDTH     = 2;
  localparam int unsigned MAX_WIDTH     = 16;

  localparam int unsigned MODE_WRAP = 0;
  localparam int unsigned MODE_SAT  = 1;

  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_COUNT = 2'd1,
    OP_LOAD  = 2'd2
  } op_e;

endpackage

// File: rtl/nand_updown_counter_if.sv
// Control/status bundle for nand_updown_counter.
//   en, load, up, din : controls driven by the master
//   count, tc, ovf    : counter state and boundary indications from the slave
interface nand_updown_counter_if
  import nand_updown_counter_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic             en;
  logic             load;
  logic             up;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             ovf;

  modport master (
    output en, load, up, din,
    input  count, tc, ovf
  );

  modport slave (
    input  en, load, up, din,
    output count, tc, ovf
  );

endinterface

// File: rtl/nand_updown_counter_dff_ar.sv
// cmos_dff_ar: 1-bit rising-edge D flip-flop with asynchronous active-low
// clear or preset. RST_VAL picks which one this bit gets. This is the
// register-level equivalent of the master-slave NAND latch pair, written
// so synthesis maps it onto a library flop.
//   clk   : clock
//   rst_n : async active-low clear/preset
//   d     : data in
//   q     : registered data out
module cmos_dff_ar #(
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  // Master transparent while clk low, slave captures on the rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RST_VAL;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/nandgate.sv
// Two-input static CMOS NAND cell.
//   a, b : inputs
//   y    : ~(a & b)
module nandgate (
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = ~(a & b);

endmodule

// File: rtl/nand_updown_counter.sv
// Parametrised up/down counter with next-state arithmetic built from NAND
// cells and per-bit async-reset flops.
//   clk   : counter clock
//   rst_n : async active-low reset (count <= RESET_VAL, ovf <= 0)
//   bus   : slave side of nand_updown_counter_if
//           en/load/up/din in; count (registered), tc (combinational),
//           ovf (registered one-cycle boundary pulse) out
module nand_updown_counter
  import nand_updown_counter_pkg::*;
#(
  parameter int unsigned      WIDTH     = DEFAULT_WIDTH,
  parameter int unsigned      SATURATE  = MODE_WRAP,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  nand_updown_counter_if.slave  bus
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0] sum;
  logic [WIDTH:0]   carry;
  logic             ovf_q;
  logic             ovf_d;
  op_e              op;

  // Per-bit NAND nets of the ripple chain.
  logic [WIDTH-1:0] n_ac, n_a1, n_c1;
  logic [WIDTH-1:0] n_au, n_a2, n_u2, x_au;
  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] n_tc;

  // Unified increment/decrement ripple: sum = a ^ c in both directions; the
  // carry (or borrow) propagates through bit i when a == up, so
  // t = xnor(a, up) and c[i+1] = t & c[i], with c[0] = 1.
  assign carry[0] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    // sum[i] = cnt_q[i] ^ carry[i]
    nandgate u_s0 (.a(cnt_q[i]), .b(carry[i]), .y(n_ac[i]));
    nandgate u_s1 (.a(cnt_q[i]), .b(n_ac[i]),  .y(n_a1[i]));
    nandgate u_s2 (.a(carry[i]), .b(n_ac[i]),  .y(n_c1[i]));
    nandgate u_s3 (.a(n_a1[i]),  .b(n_c1[i]),  .y(sum[i]));

    // t[i] = ~(cnt_q[i] ^ up)
    nandgate u_p0 (.a(cnt_q[i]), .b(bus.up),   .y(n_au[i]));
    nandgate u_p1 (.a(cnt_q[i]), .b(n_au[i]),  .y(n_a2[i]));
    nandgate u_p2 (.a(bus.up),   .b(n_au[i]),  .y(n_u2[i]));
    nandgate u_p3 (.a(n_a2[i]),  .b(n_u2[i]),  .y(x_au[i]));
    nandgate u_p4 (.a(x_au[i]),  .b(x_au[i]),  .y(t[i]));

    // carry[i+1] = t[i] & carry[i]
    nandgate u_c0 (.a(t[i]),     .b(carry[i]), .y(n_tc[i]));
    nandgate u_c1 (.a(n_tc[i]),  .b(n_tc[i]),  .y(carry[i+1]));
  end

  // Operation decode: load beats en, otherwise hold.
  always_comb begin
    op = OP_HOLD;
    if (bus.load) begin
      op = OP_LOAD;
    end else if (bus.en) begin
      op = OP_COUNT;
    end
  end

  // Next-state mux. The final carry is set exactly at the boundary for the
  // current direction, so it doubles as the boundary/ovf condition. din only
  // reaches cnt_d under OP_LOAD, keeping an unknown din out of the counter.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = 1'b0;
    unique case (op)
      OP_LOAD: begin
        cnt_d = bus.din;
      end
      OP_COUNT: begin
        ovf_d = carry[WIDTH];
        if (!(carry[WIDTH] && (SATURATE == MODE_SAT))) begin
          cnt_d = sum;
        end
      end
      default: begin
      end
    endcase
  end

  // State flops: per-bit clear or preset taken from RESET_VAL.
  for (genvar i = 0; i < WIDTH; i++) begin : g_ff
    cmos_dff_ar #(
      .RST_VAL (RESET_VAL[i])
    ) u_cnt_ff (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (cnt_d[i]),
      .q     (cnt_q[i])
    );
  end

  cmos_dff_ar #(
    .RST_VAL (1'b0)
  ) u_ovf_ff (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (ovf_d),
    .q     (ovf_q)
  );

  assign bus.count = cnt_q;
  assign bus.ovf   = ovf_q;
  // Terminal count tracks up with no latency.
  assign bus.tc    = carry[WIDTH];

endmodule
